// File: rtl/stack_pointer.sv
// ---------------------------------------------------------------------------
// stack_pointer
//   Registered stack pointer with one-cycle push/pop and saturating bounds.
//   SP counts up from BASE (empty) to BASE+DEPTH (full). A push at full or
//   a pop at empty is dropped, so SP never wraps outside that window.
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   asynchronous reset, active low (forces SP to BASE at once)
//   newSP  in   [1:0] op: 00 hold, 01 push, 10 pop, 11 reserved (hold)
//   SP     out  [WIDTH-1:0] registered stack pointer
//   empty  out  SP == BASE
//   full   out  SP == BASE+DEPTH
// ---------------------------------------------------------------------------
module stack_pointer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned BASE  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       newSP,
    output logic [WIDTH-1:0] SP,
    output logic             empty,
    output logic             full
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;

    // Both bounds are fixed at elaboration; DEPTH >= 1 keeps them distinct.
    localparam logic [WIDTH-1:0] SP_EMPTY = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] SP_FULL  = WIDTH'(BASE + DEPTH);

    logic [WIDTH-1:0] sp_q;
    logic [WIDTH-1:0] sp_d;
    logic             empty_w;
    logic             full_w;

    // Flags decode straight from the register so they always match SP.
    assign empty_w = (sp_q == SP_EMPTY);
    assign full_w  = (sp_q == SP_FULL);

    always_comb begin
        sp_d = sp_q;
        unique case (newSP)
            OP_PUSH: if (!full_w)  sp_d = sp_q + WIDTH'(1);
            OP_POP:  if (!empty_w) sp_d = sp_q - WIDTH'(1);
            OP_HOLD: sp_d = sp_q;
            default: sp_d = sp_q; // reserved code holds
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sp_q <= SP_EMPTY;
        else        sp_q <= sp_d;
    end

    assign SP    = sp_q;
    assign empty = empty_w;
    assign full  = full_w;

endmodule

// File: tb/tb_stack_pointer.sv
// ---------------------------------------------------------------------------
// tb_stack_pointer
//   Scoreboarded bench. The driver applies one op per cycle at the falling
//   edge and pushes the expected post-edge SP/empty/full (from an entry-count
//   model) into a queue; a monitor pops and compares 1 time unit after each
//   rising edge. Asynchronous reset behaviour is checked directly.
// ---------------------------------------------------------------------------
module tb_stack_pointer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BASE  = 0;

    typedef struct {
        logic [WIDTH-1:0] sp;
        logic             e;
        logic             f;
    } exp_t;

    logic             clock;
    logic             reset;
    logic [1:0]       newSP;
    logic [WIDTH-1:0] SP;
    logic             empty;
    logic             full;

    exp_t exp_q[$];
    int   cnt;        // entries held according to the model
    int   checks;
    int   errors;

    stack_pointer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .newSP (newSP),
        .SP    (SP),
        .empty (empty),
        .full  (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input int n);
        exp_t x;
        x.sp = WIDTH'(BASE + n);
        x.e  = (n == 0);
        x.f  = (n == DEPTH);
        return x;
    endfunction

    task automatic cmp(input string name, input exp_t x);
        checks++;
        if (SP !== x.sp || empty !== x.e || full !== x.f) begin
            errors++;
            $display("FAIL %s: got SP=%0d empty=%b full=%b, want SP=%0d empty=%b full=%b",
                     name, SP, empty, full, x.sp, x.e, x.f);
        end
    endtask

    // One op per cycle: reset level and op take effect at the next rising edge.
    task automatic step(input logic rst, input logic [1:0] op);
        @(negedge clock);
        reset = rst;
        newSP = op;
        if (!rst)                                cnt = 0;
        else if (op == 2'b01 && cnt < int'(DEPTH)) cnt++;
        else if (op == 2'b10 && cnt > 0)         cnt--;
        exp_q.push_back(mk(cnt));
    endtask

    // Monitor: SP is presented every cycle, so every edge that has a pending
    // expectation is compared.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            cmp("sb", x);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cnt    = 0;
        reset  = 1'b0;
        newSP  = 2'b01;
        #2;
        cmp("reset_state", mk(0));

        // Push requested while reset is held: still BASE.
        step(1'b0, 2'b01);
        step(1'b0, 2'b10);

        // Release and push on the first edge with reset high.
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        step(1'b1, 2'b00);                   // hold -> 0, empty
        step(1'b1, 2'b01);                   // 1
        step(1'b1, 2'b01);                   // 2
        step(1'b1, 2'b10);                   // 1
        step(1'b1, 2'b10);                   // 0
        step(1'b1, 2'b10);                   // pop at empty -> stays 0
        step(1'b1, 2'b10);
        for (int i = 0; i < 17; i++) step(1'b1, 2'b01);   // saturate at full
        step(1'b1, 2'b01);
        for (int i = 0; i < 13; i++) step(1'b1, 2'b10);   // down to 3
        step(1'b1, 2'b11);                   // reserved -> hold at 3
        step(1'b1, 2'b11);
        step(1'b1, 2'b01);                   // 4
        step(1'b1, 2'b01);                   // 5

        // Async reset between edges at SP=5.
        @(posedge clock);
        #3;
        cmp("pre_async_rst", mk(5));
        reset = 1'b0;
        cnt   = 0;
        #1;
        cmp("async_rst", mk(0));
        if ($isunknown({SP, empty, full})) begin
            checks++;
            errors++;
            $display("FAIL x_after_reset: got SP=%h empty=%b full=%b, want known values",
                     SP, empty, full);
        end else checks++;
        step(1'b1, 2'b01);                   // first edge after release -> 1

        // Random ops with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic rst;
            rst = ($urandom_range(0, 49) != 0);
            step(rst, 2'($urandom_range(0, 3)));
        end
        // Bias toward the full boundary.
        for (int i = 0; i < 60; i++)
            step(1'b1, ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3)));

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clock);
                #2;
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_pointer.md
STACK_POINTER -- requirements
Module: stack_pointer

Interface
REQ-001 Parameter: WIDTH, 32, bit width of SP.
REQ-002 Parameter: DEPTH, 16, number of stack entries; legal range 1 to 2^WIDTH-1.
REQ-003 Parameter: BASE, 0, SP value when the stack is empty.
REQ-004 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: SP  output  WIDTH  registered stack pointer; number of entries held = SP - BASE.
REQ-007 Port: newSP  input  2  operation select: stackPointerDef=2'b00 hold, stackPointerPush=2'b01 push, stackPointerPop=2'b10 pop, 2'b11 reserved.
REQ-008 Port: empty  output  1  high when SP == BASE.
REQ-009 Port: full  output  1  high when SP == BASE+DEPTH.

Function
REQ-010 The block SHALL sample newSP on each rising clock edge while reset is high.
REQ-011 Hold (2'b00) SHALL leave SP unchanged.
REQ-012 Push (2'b01) with full low SHALL set SP to SP+1 at that edge.
REQ-013 Pop (2'b10) with empty low SHALL set SP to SP-1 at that edge.
REQ-014 Push while full is high SHALL be ignored; SP holds and does not wrap.
REQ-015 Pop while empty is high SHALL be ignored; SP holds and does not wrap below BASE.
REQ-016 Reserved code 2'b11 SHALL behave as hold.
REQ-017 Latency SHALL be one cycle: the SP change is visible immediately after the sampling edge.
REQ-018 empty and full SHALL be decoded combinationally from the registered SP, so they are always consistent with SP in the same cycle.
REQ-019 empty and full SHALL never be high together; with DEPTH>=1, BASE and BASE+DEPTH are distinct.
REQ-020 SP SHALL always stay within BASE to BASE+DEPTH inclusive.
REQ-021 SP arithmetic SHALL be unsigned WIDTH-bit.
REQ-022 The block SHALL have no handshake; each cycle performs at most one operation.

Reset
REQ-023 While reset is low, SP SHALL be forced to BASE immediately, without waiting for a clock edge.
REQ-024 During reset, empty SHALL be 1 and full SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL override any pending push or pop.
REQ-026 The first operation after reset deassertion SHALL take effect at the first rising edge on which reset is high.
REQ-027 No output SHALL be X or Z after reset.

Verification
REQ-028 Reset then hold (newSP=00) for 1 cycle -> SP=0, empty=1, full=0.
REQ-029 From reset: push, push, pop on consecutive 10-unit clock cycles -> SP=1, then 2, then 1; empty=0 after the first push.
REQ-030 Pop when SP=0 -> SP stays 0, empty stays 1.
REQ-031 Push 16 times with DEPTH=16 -> SP=16 and full=1; a 17th push -> SP stays 16.
REQ-032 Code 2'b11 applied at SP=3 -> SP stays 3.
REQ-033 Assert reset asynchronously between edges at SP=5 -> SP=0 and empty=1 before the next edge; the push sampled on the first edge after release -> SP=1.
